// File: rtl/riscv_muldiv_unit_if.sv
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
interface riscv_muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in, flush,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, flush,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier and
// restoring divider working on operand magnitudes, with a final sign fixup.
module riscv_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    riscv_muldiv_unit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  count;
    logic [2:0]        op_q;
    logic              sign_a, sign_b;
    logic [XLEN-1:0]   acc;       // product high half / partial remainder
    logic [XLEN-1:0]   lo;        // multiplier bits / dividend-then-quotient bits
    logic [XLEN-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]   result_q;
    logic [4:0]        rd_tag, rd_q;

    // Accept-time decode
    logic              accept, is_div, a_signed, b_signed, neg_a, neg_b;
    logic              div_zero, div_ovf, special;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;

    assign accept   = (state == IDLE) && bus.start && !bus.flush;
    assign is_div   = bus.funct3[2];
    assign a_signed = (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                      (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
    assign b_signed = (bus.funct3 == F_MULH) || (bus.funct3 == F_DIV) ||
                      (bus.funct3 == F_REM);
    assign neg_a    = a_signed && bus.op_a[XLEN-1];
    assign neg_b    = b_signed && bus.op_b[XLEN-1];
    assign a_mag    = neg_a ? -bus.op_a : bus.op_a;
    assign b_mag    = neg_b ? -bus.op_b : bus.op_b;

    assign div_zero = is_div && (bus.op_b == '0);
    assign div_ovf  = is_div && !bus.funct3[0] && (bus.op_a == MOST_NEG) &&
                      (bus.op_b == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        special_res = '0;
        if (div_zero)
            special_res = bus.funct3[1] ? bus.op_a : '1;
        else if (div_ovf)
            special_res = bus.funct3[1] ? '0 : bus.op_a;
    end

    // One iteration of each datapath
    logic [XLEN:0]   mul_sum, div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;

    assign mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc, lo[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift[XLEN-1:0] - opnd;

    // Sign fixup and half selection
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix, fix_res;

    assign prod_fix = (sign_a ^ sign_b) ? -{acc, lo} : {acc, lo};
    assign quot_fix = (sign_a ^ sign_b) ? -lo : lo;
    assign rem_fix  = sign_a ? -acc : acc;

    always_comb begin
        fix_res = prod_fix[2*XLEN-1:XLEN];
        if (op_q[2])
            fix_res = op_q[1] ? rem_fix : quot_fix;
        else if (op_q == F_MUL)
            fix_res = prod_fix[XLEN-1:0];
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = special ? DONE : CALC;
            CALC:    if (count == LAST_ITER) state_next = FIXUP;
            FIXUP:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush && (state != IDLE))
            state_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            op_q     <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            acc      <= '0;
            lo       <= '0;
            opnd     <= '0;
            result_q <= '0;
            rd_tag   <= '0;
            rd_q     <= '0;
        end else if (accept) begin
            count  <= '0;
            op_q   <= bus.funct3;
            rd_tag <= bus.rd_in;
            sign_a <= neg_a;
            sign_b <= neg_b;
            acc    <= '0;
            opnd   <= is_div ? b_mag : a_mag;
            lo     <= is_div ? a_mag : b_mag;
            if (special) begin
                result_q <= special_res;
                rd_q     <= bus.rd_in;
            end
        end else if ((state == CALC) && !bus.flush) begin
            count <= count + 1'b1;
            if (op_q[2]) begin
                acc <= div_ge ? div_diff : div_shift[XLEN-1:0];
                lo  <= {lo[XLEN-2:0], div_ge};
            end else begin
                acc <= mul_sum[XLEN:1];
                lo  <= {mul_sum[0], lo[XLEN-1:1]};
            end
        end else if ((state == FIXUP) && !bus.flush) begin
            result_q <= fix_res;
            rd_q     <= rd_tag;
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign bus.rd_out = rd_q;
endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit (XLEN=32): directed vectors,
// random operations against an arithmetic reference, and handshake corners.
module tb_riscv_muldiv_unit;
    localparam int XLEN = 32;
    localparam int NORMAL_LAT = XLEN + 2;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    riscv_muldiv_unit_if #(.XLEN(XLEN)) bus();
    riscv_muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: RISC-V M semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == MIN_NEG && b == 32'hFFFF_FFFF)))
            return 1;
        return NORMAL_LAT;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return MIN_NEG;
            default: return $urandom;
        endcase
    endfunction

    // Issue one op; lat = cycle (1 = first cycle after accept) done was seen, 0 on timeout.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output int lat, output int busy_cnt);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = rd;
        lat = 0;
        busy_cnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) begin
                bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom; bus.rd_in = 5'($urandom);
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin lat = n; break; end
        end
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    initial begin
        vec_t vecs[$];
        int lat, busy_cnt, done_cnt;
        logic [31:0] held_res;
        logic [4:0]  held_rd;

        vecs.push_back('{3'd0, 32'd7,         32'd6,         5'd5,  32'h0000_002A, 34});
        vecs.push_back('{3'd1, 32'hFFFF_FFFD, 32'd5,         5'd1,  32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 34});
        vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFD, 34});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd5, 32'd100,       32'd7,         5'd7,  32'd14,        34});
        vecs.push_back('{3'd7, 32'd100,       32'd7,         5'd8,  32'd2,         34});
        vecs.push_back('{3'd4, 32'd5,         32'd0,         5'd9,  32'hFFFF_FFFF, 1});
        vecs.push_back('{3'd7, 32'd5,         32'd0,         5'd10, 32'd5,         1});
        vecs.push_back('{3'd4, MIN_NEG,       32'hFFFF_FFFF, 5'd11, MIN_NEG,       1});
        vecs.push_back('{3'd6, MIN_NEG,       32'hFFFF_FFFF, 5'd12, 32'h0,         1});
        vecs.push_back('{3'd1, MIN_NEG,       MIN_NEG,       5'd13, 32'h4000_0000, 34});
        vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'h1,         34});
        vecs.push_back('{3'd5, MIN_NEG,       32'hFFFF_FFFF, 5'd15, 32'h0,         34});
        vecs.push_back('{3'd4, 32'd7,         32'hFFFF_FFFE, 5'd16, 32'hFFFF_FFFD, 34});
        vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFF, 34});
        vecs.push_back('{3'd5, 32'd5,         32'd0,         5'd18, 32'hFFFF_FFFF, 1});

        bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;
        bus.rd_in = '0; bus.flush = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy",   {63'b0, bus.busy}, 64'd0);
        check("reset done",   {63'b0, bus.done}, 64'd0);
        check("reset result", {32'b0, bus.result}, 64'd0);
        check("reset rd_out", {59'b0, bus.rd_out}, 64'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, lat, busy_cnt);
            check($sformatf("vec%0d latency", i),   64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d busy_cyc", i),  64'(busy_cnt), 64'(vecs[i].lat));
            check($sformatf("vec%0d result", i),    {32'b0, bus.result}, {32'b0, vecs[i].exp});
            check($sformatf("vec%0d rd_out", i),    {59'b0, bus.rd_out}, {59'b0, vecs[i].rd});
            @(negedge clk);
            check($sformatf("vec%0d idle", i),      {62'b0, bus.busy, bus.done}, 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0] f;
            logic [31:0] a, b;
            logic [4:0] rd;
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            rd = 5'($urandom);
            run_op(f, a, b, rd, lat, busy_cnt);
            check($sformatf("rnd%0d f%0d latency", i, f), 64'(lat), 64'(ref_latency(f, a, b)));
            check($sformatf("rnd%0d f%0d %0h,%0h result", i, f, a, b),
                  {32'b0, bus.result}, {32'b0, ref_result(f, a, b)});
            check($sformatf("rnd%0d rd_out", i), {59'b0, bus.rd_out}, {59'b0, rd});
        end

        // Second start while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd1234; bus.op_b = 32'd5678; bus.rd_in = 5'd3;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (n == 3) begin
                bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd99; bus.op_b = 32'd0; bus.rd_in = 5'd9;
            end
            if (n == 4) bus.start = 1'b0;
            if (bus.done) begin lat = n; break; end
        end
        check("busy_start latency", 64'(lat), 64'(NORMAL_LAT));
        check("busy_start result", {32'b0, bus.result}, {32'b0, ref_result(3'd0, 32'd1234, 32'd5678)});
        check("busy_start rd_out", {59'b0, bus.rd_out}, 64'd3);
        held_res = ref_result(3'd0, 32'd1234, 32'd5678);
        held_rd  = 5'd3;

        // Flush mid-calculation: no done, outputs hold.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd100; bus.op_b = 32'd200; bus.rd_in = 5'd7;
        done_cnt = 0;
        for (int n = 1; n <= 50; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
            if (bus.done) done_cnt++;
            if (n == 10) bus.flush = 1'b1;
            if (n == 11) begin
                bus.flush = 1'b0;
                check("flush busy drop", {63'b0, bus.busy}, 64'd0);
            end
        end
        check("flush no done", 64'(done_cnt), 64'd0);
        check("flush result held", {32'b0, bus.result}, {32'b0, held_res});
        check("flush rd held", {59'b0, bus.rd_out}, {59'b0, held_rd});

        run_op(3'd5, 32'd100, 32'd7, 5'd12, lat, busy_cnt);
        check("post_flush latency", 64'(lat), 64'(NORMAL_LAT));
        check("post_flush result", {32'b0, bus.result}, 64'd14);
        check("post_flush rd_out", {59'b0, bus.rd_out}, 64'd12);

        // start together with flush in IDLE is refused.
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd5; bus.op_b = 32'd0;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        check("start_flush busy", {62'b0, bus.busy, bus.done}, 64'd0);
        check("start_flush result", {32'b0, bus.result}, 64'd14);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd1000; bus.op_b = 32'd3; bus.rd_in = 5'd21;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (n == 1) bus.start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("async rst busy",   {63'b0, bus.busy}, 64'd0);
        check("async rst done",   {63'b0, bus.done}, 64'd0);
        check("async rst result", {32'b0, bus.result}, 64'd0);
        check("async rst rd_out", {59'b0, bus.rd_out}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3'd0, 32'd3, 32'd3, 5'd4, lat, busy_cnt);
        check("post_rst latency", 64'(lat), 64'(NORMAL_LAT));
        check("post_rst result", {32'b0, bus.result}, 64'd9);
        check("post_rst rd_out", {59'b0, bus.rd_out}, 64'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
